// File: rtl/param_switch.sv
// N-port packet switch: per-input address/data packets routed by address low bits
// (all-ones address = broadcast) into per-output FIFOs with round-robin arbitration.

module param_switch_fifo #(
   parameter int WIDTH = 80,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic             full,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             pop;

   // Full is taken from registered occupancy, so a pop never frees a slot in the same cycle.
   assign full       = (count == CNT_W'(DEPTH));
   assign head_valid = !reset && (count != '0);
   assign head_data  = head_valid ? mem[rd_ptr] : '0;
   assign pop        = head_valid && pop_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end
endmodule

module param_switch #(
   parameter int ADDR_W     = 48,
   parameter int DATA_W     = 32,
   parameter int N_PORTS    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_PORTS-1:0]        in_valid,
   output logic [N_PORTS-1:0]        in_ready,
   input  logic [N_PORTS*ADDR_W-1:0] in_addr,
   input  logic [N_PORTS*DATA_W-1:0] in_data,
   output logic [N_PORTS-1:0]        out_valid,
   input  logic [N_PORTS-1:0]        out_ready,
   output logic [N_PORTS*ADDR_W-1:0] out_addr,
   output logic [N_PORTS*DATA_W-1:0] out_data
);
   localparam int PSEL_W = $clog2(N_PORTS);
   localparam int PKT_W  = ADDR_W + DATA_W;

   logic [N_PORTS-1:0][ADDR_W-1:0]  addr_a, oaddr_a;
   logic [N_PORTS-1:0][DATA_W-1:0]  data_a, odata_a;
   logic [N_PORTS-1:0][N_PORTS-1:0] uc_req;      // [output][input]
   logic [N_PORTS-1:0]              bc_req, fifo_full, uc_vld, uc_push;
   logic [N_PORTS-1:0][PSEL_W-1:0]  rr_ptr, uc_idx;
   logic [PSEL_W-1:0]               bc_ptr, bc_idx;
   logic                            bc_any, bc_accept;
   logic [N_PORTS-1:0][PKT_W-1:0]   push_pkt, head_pkt;

   assign addr_a   = in_addr;
   assign data_a   = in_data;
   assign out_addr = oaddr_a;
   assign out_data = odata_a;

   always_comb begin
      bc_req = '0;
      uc_req = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (in_valid[i]) begin
            if (&addr_a[i]) bc_req[i] = 1'b1;
            else            uc_req[addr_a[i][PSEL_W-1:0]][i] = 1'b1;
         end
      end
   end

   // Scan from the highest offset down so the requester closest at/after the pointer wins.
   always_comb begin
      logic [PSEL_W-1:0] idx;
      idx    = '0;
      uc_vld = '0;
      uc_idx = '0;
      bc_idx = '0;
      for (int o = 0; o < N_PORTS; o++) begin
         for (int k = N_PORTS-1; k >= 0; k--) begin
            idx = rr_ptr[o] + PSEL_W'(k);
            if (uc_req[o][idx]) begin
               uc_vld[o] = 1'b1;
               uc_idx[o] = idx;
            end
         end
      end
      for (int k = N_PORTS-1; k >= 0; k--) begin
         idx = bc_ptr + PSEL_W'(k);
         if (bc_req[idx]) bc_idx = idx;
      end
   end

   // Any pending broadcast freezes unicast traffic until it gets through.
   assign bc_any    = |bc_req;
   assign bc_accept = !reset && bc_any && !(|fifo_full);
   assign uc_push   = (reset || bc_any) ? '0 : (uc_vld & ~fifo_full);

   always_comb begin
      in_ready = '0;
      for (int o = 0; o < N_PORTS; o++) begin
         if (uc_push[o]) in_ready[uc_idx[o]] = 1'b1;
         push_pkt[o] = bc_accept ? {addr_a[bc_idx], data_a[bc_idx]}
                                 : {addr_a[uc_idx[o]], data_a[uc_idx[o]]};
      end
      if (bc_accept) in_ready[bc_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
         bc_ptr <= '0;
      end else begin
         for (int o = 0; o < N_PORTS; o++)
            if (uc_push[o]) rr_ptr[o] <= uc_idx[o] + 1'b1;
         if (bc_accept) bc_ptr <= bc_idx + 1'b1;
      end
   end

   for (genvar o = 0; o < N_PORTS; o++) begin : g_out
      param_switch_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk        (clk),
         .reset      (reset),
         .push       (uc_push[o] || bc_accept),
         .push_data  (push_pkt[o]),
         .pop_ready  (out_ready[o]),
         .full       (fifo_full[o]),
         .head_valid (out_valid[o]),
         .head_data  (head_pkt[o])
      );
      assign oaddr_a[o] = head_pkt[o][PKT_W-1:DATA_W];
      assign odata_a[o] = head_pkt[o][DATA_W-1:0];
   end
endmodule

// File: tb/tb_param_switch.sv
// Bench for param_switch: table-driven arbitration vectors, hand sequences for
// backpressure/broadcast/reset, and a per-output scoreboard on every popped packet.

module tb_param_switch;
   localparam int N = 4;
   localparam int AW = 48;
   localparam int DW = 32;
   typedef logic [AW+DW-1:0] pkt_t;

   logic clk, reset;
   logic [N-1:0] t_valid, in_ready, out_valid, t_out_ready;
   logic [N-1:0][AW-1:0] t_addr, o_addr;
   logic [N-1:0][DW-1:0] t_data, o_data;
   logic [N*AW-1:0] out_addr;
   logic [N*DW-1:0] out_data;

   int checks, errors;
   int sent [N];
   pkt_t exp_q [N][$];

   param_switch #(.ADDR_W(AW), .DATA_W(DW), .N_PORTS(N), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(t_valid), .in_ready(in_ready),
      .in_addr(t_addr), .in_data(t_data),
      .out_valid(out_valid), .out_ready(t_out_ready),
      .out_addr(out_addr), .out_data(out_data)
   );
   assign o_addr = out_addr;
   assign o_data = out_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: capture accepted packets and compare popped heads in order.
   always @(negedge clk) begin
      if (reset) begin
         for (int o = 0; o < N; o++) exp_q[o].delete();
      end else begin
         for (int o = 0; o < N; o++) begin
            if (out_valid[o] && t_out_ready[o]) begin
               checks++;
               if (exp_q[o].size() == 0) begin
                  errors++;
                  $display("FAIL sb_extra out%0d got %h_%h required nothing", o, o_addr[o], o_data[o]);
               end else begin
                  pkt_t e;
                  e = exp_q[o].pop_front();
                  if ({o_addr[o], o_data[o]} !== e) begin
                     errors++;
                     $display("FAIL sb_order out%0d got %h_%h required %h", o, o_addr[o], o_data[o], e);
                  end
               end
            end
         end
         checks++;
         if ((in_ready & ~t_valid) != '0) begin
            errors++;
            $display("FAIL ready_wo_valid got in_ready %b in_valid %b", in_ready, t_valid);
         end
         for (int i = 0; i < N; i++) begin
            if (t_valid[i] && in_ready[i]) begin
               if (&t_addr[i]) for (int o = 0; o < N; o++) exp_q[o].push_back({t_addr[i], t_data[i]});
               else exp_q[t_addr[i][1:0]].push_back({t_addr[i], t_data[i]});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, exp);
      end
   endtask

   task automatic send(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      n = 0;
      t_valid[p] = 1'b1; t_addr[p] = a; t_data[p] = d;
      #1;
      while (!in_ready[p] && n < 30) begin step(); #1; n++; end
      checks++;
      if (!in_ready[p]) begin errors++; $display("FAIL send_timeout port %0d got no ready required ready", p); end
      step();
      t_valid[p] = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0]      valid;
      logic [N-1:0][1:0] dest;
      logic [N-1:0]      exp_ready;
   } vec_t;
   vec_t tbl [10];

   initial begin
      logic [3:0] rr_exp [3];
      tbl[0] = '{4'b1011, {2'd1, 2'd1, 2'd1, 2'd1}, 4'b0001};
      tbl[1] = '{4'b1011, {2'd1, 2'd1, 2'd1, 2'd1}, 4'b0010};
      tbl[2] = '{4'b1011, {2'd1, 2'd1, 2'd1, 2'd1}, 4'b1000};
      tbl[3] = '{4'b1011, {2'd1, 2'd1, 2'd1, 2'd1}, 4'b0001};
      tbl[4] = '{4'b1011, {2'd1, 2'd1, 2'd1, 2'd1}, 4'b0010};
      tbl[5] = '{4'b1011, {2'd1, 2'd1, 2'd1, 2'd1}, 4'b1000};
      tbl[6] = '{4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b1111};
      tbl[7] = '{4'b0011, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0010};
      tbl[8] = '{4'b0011, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0001};
      tbl[9] = '{4'b0000, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000};
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000;
      checks = 0; errors = 0;
      for (int p = 0; p < N; p++) sent[p] = 0;

      // Reset state, with a valid input present
      reset = 1'b1; t_valid = 4'b0001; t_addr = '0; t_data = '0; t_out_ready = '1;
      step(); step();
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_addr", 64'(out_addr[63:0]), 64'h0);
      reset = 1'b0; t_valid = '0;
      step();

      // Single unicast to output 2
      t_valid[0] = 1'b1; t_addr[0] = 48'h2; t_data[0] = 32'hDEADBEEF;
      #1 chk("uc_ready", 64'(in_ready), 64'b0001);
      step();
      t_valid[0] = 1'b0;
      #1 chk("uc_out_valid", 64'(out_valid), 64'b0100);
      chk("uc_out_addr", 64'(o_addr[2]), 64'h2);
      chk("uc_out_data", 64'(o_data[2]), 64'hDEADBEEF);
      step();

      // Arbitration vectors
      for (int r = 0; r < 10; r++) begin
         for (int p = 0; p < N; p++) begin
            t_valid[p] = tbl[r].valid[p];
            t_addr[p]  = AW'(tbl[r].dest[p]);
            t_data[p]  = 32'hC000_0000 | (32'(p) << 8) | 32'(sent[p]);
         end
         #1 chk($sformatf("tbl%0d_ready", r), 64'(in_ready), 64'(tbl[r].exp_ready));
         for (int p = 0; p < N; p++) if (in_ready[p]) sent[p]++;
         step();
      end
      repeat (4) step();

      // Backpressure on output 3
      t_out_ready[3] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         t_valid[0] = 1'b1; t_addr[0] = 48'h3; t_data[0] = 32'hB000_0000 + 32'(k);
         #1 chk($sformatf("bp_accept%0d", k), 64'(in_ready[0]), 64'h1);
         step();
      end
      t_data[0] = 32'hB000_0004;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("bp_full%0d", k), 64'(in_ready[0]), 64'h0);
         step();
      end
      chk("bp_head", 64'(o_data[3]), 64'hB000_0000);
      t_out_ready[3] = 1'b1;
      #1 chk("bp_no_passthru", 64'(in_ready[0]), 64'h0);
      step();
      #1 chk("bp_resume4", 64'(in_ready[0]), 64'h1);
      step();
      t_data[0] = 32'hB000_0005;
      #1 chk("bp_resume5", 64'(in_ready[0]), 64'h1);
      step();
      t_valid[0] = 1'b0;
      repeat (8) step();

      // Broadcast competing with a unicast
      t_valid = 4'b0101;
      t_addr[2] = '1;    t_data[2] = 32'h12345678;
      t_addr[0] = 48'h1; t_data[0] = 32'hAAAA_0001;
      #1 chk("bc_alone", 64'(in_ready), 64'b0100);
      step();
      t_valid[2] = 1'b0;
      #1 chk("bc_out_valid", 64'(out_valid), 64'b1111);
      for (int o = 0; o < N; o++) chk($sformatf("bc_data%0d", o), 64'(o_data[o]), 64'h12345678);
      chk("bc_uc_next", 64'(in_ready), 64'b0001);
      step();
      t_valid[0] = 1'b0;
      repeat (4) step();

      // Broadcast blocked by a full output 1
      t_out_ready[1] = 1'b0;
      for (int k = 0; k < 4; k++) send(1, 48'h1, 32'hF100_0000 + 32'(k));
      t_valid = 4'b1001;
      t_addr[3] = '1;    t_data[3] = 32'hBBBB_0003;
      t_addr[0] = 48'h2; t_data[0] = 32'hAAAA_0002;
      #1 chk("bb_blocked0", 64'(in_ready), 64'b0000);
      step();
      #1 chk("bb_blocked1", 64'(in_ready), 64'b0000);
      step();
      t_out_ready[1] = 1'b1;
      #1 chk("bb_prepop", 64'(in_ready), 64'b0000);
      step();
      t_out_ready[1] = 1'b0;
      #1 chk("bb_accept", 64'(in_ready), 64'b1000);
      step();
      t_valid[3] = 1'b0;
      #1 chk("bb_uc_after", 64'(in_ready), 64'b0001);
      step();
      t_valid[0] = 1'b0;
      t_out_ready[1] = 1'b1;
      repeat (10) step();

      // Reset with packets buffered
      t_out_ready = '0;
      t_valid = 4'b0111;
      t_addr[0] = 48'h0; t_addr[1] = 48'h1; t_addr[2] = 48'h2;
      t_data[0] = 32'hD000_0000; t_data[1] = 32'hD000_0001; t_data[2] = 32'hD000_0002;
      #1 chk("mr_ready", 64'(in_ready), 64'b0111);
      step();
      t_valid = '0;
      #1 chk("mr_buffered", 64'(out_valid), 64'b0111);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1 chk("mr_out_valid", 64'(out_valid), 64'h0);
      chk("mr_out_addr", 64'(o_addr[1]), 64'h0);
      chk("mr_out_data", 64'(o_data[2]), 64'h0);
      t_out_ready = '1;
      for (int r = 0; r < 3; r++) begin
         t_valid = 4'b1011;
         for (int p = 0; p < N; p++) begin
            t_addr[p] = 48'h1;
            t_data[p] = 32'hE000_0000 | (32'(p) << 8) | 32'(sent[p]);
         end
         #1 chk($sformatf("mr_rr%0d", r), 64'(in_ready), 64'(rr_exp[r]));
         for (int p = 0; p < N; p++) if (in_ready[p]) sent[p]++;
         step();
      end
      t_valid = '0;
      repeat (10) step();

      for (int o = 0; o < N; o++) chk($sformatf("sb_empty%0d", o), 64'(exp_q[o].size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
